paint_scheduler: RTL and testbench
==================================

PAINT_SCHEDULER -- requirements
Module: paint_scheduler

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixel columns.
REQ-002 Parameter V_ACTIVE, default 480, visible pixel rows.
REQ-003 clk  input  1  pixel clock; the only clock; all state on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 cmd_valid  input  1  paint command present.
REQ-006 cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high on a clk edge.
REQ-007 cmd_x  input  10  brush centre column.
REQ-008 cmd_y  input  10  brush centre row.
REQ-009 cmd_color  input  3  colour code to write.
REQ-010 cmd_size  input  2  brush radius r; square side 2r+1 (1, 3, 5, 7).
REQ-011 cmd_brush  input  1  1 = paint cmd_color; 0 = erase (colour 3'b000).
REQ-012 clear_req  input  1  single-cycle request to clear the whole screen.
REQ-013 wr_allow  input  1  pixel-store write slot available this cycle.
REQ-014 wr_en  output  1  pixel-store write strobe.
REQ-015 wr_x, wr_y  output  10 each  write address, column and row.
REQ-016 wr_color  output  3  write data.
REQ-017 busy  output  1  high in any state other than IDLE, or while a clear is pending.

Function
REQ-018 States: IDLE, PAINT, CLEAR; encoding is free.
REQ-019 cmd_ready shall be high only in IDLE with no clear pending (combinational from state).
REQ-020 Command accept latches centre, colour (0 if cmd_brush=0), and r, then enters PAINT.
- The PAINT scan start is (cmd_x-r, cmd_y-r).
REQ-021 Coordinate arithmetic shall be 11-bit signed; no wrap-around, so a negative coordinate never aliases to a large one.
REQ-022 PAINT scans (2r+1)^2 positions row-major: x increments first, y increments at row end.
REQ-023 In-range position: 0<=x<H_ACTIVE and 0<=y<V_ACTIVE.
- wr_en = in-range AND wr_allow (combinational from wr_allow).
- The scan advances only when wr_en=1.
REQ-024 Out-of-range position: no write; the scan advances unconditionally, one cycle per position.
REQ-025 The first wr_en may assert in the cycle after accept; after the last position the block returns to IDLE on the next edge.
REQ-026 A clear_req pulse in any state except CLEAR sets clear_pend; a clear_req in CLEAR is ignored.
REQ-027 In IDLE with clear_pend set, the block enters CLEAR and clears clear_pend; this takes priority over a simultaneous cmd_valid, which is not accepted.
REQ-028 A clear_req arriving during PAINT shall not abort PAINT; CLEAR starts after PAINT completes.
REQ-029 CLEAR writes colour 0 to (0,0) .. (H_ACTIVE-1, V_ACTIVE-1) row-major, advancing only when wr_allow=1, then returns to IDLE.
REQ-030 wr_x, wr_y, wr_color shall hold the current scan position and colour whenever wr_en=1; they are don't-care otherwise.
REQ-031 With wr_allow held low, PAINT/CLEAR stall indefinitely on an in-range position and no address is skipped.

Reset
REQ-032 reset_n low shall immediately force: state IDLE, clear_pend 0, wr_en 0, wr_x/wr_y/wr_color 0, busy 0, cmd_ready 0.
REQ-033 cmd_ready returns high in the first cycle after reset_n deasserts.
REQ-034 Reset mid-PAINT or mid-CLEAR abandons the operation with no further writes; there is no resume.

Structure
REQ-035 Shared package paint_pkg shall hold:
- H_ACTIVE/V_ACTIVE defaults;
- the colour-code typedef (3-bit);
- the coordinate typedef (10-bit);
- ERASE_COLOR = 3'b000;
- the state enum.
REQ-036 One sub-module, rect_scanner, shall hold the row-major x/y counters with start/extent/advance/done, shared by PAINT and CLEAR.

Verification
REQ-037 Basic paint: cmd (100,50), r=1, colour 5, wr_allow=1 -> 9 consecutive writes (99,49)..(101,51) row-major, colour 5, then cmd_ready high.
REQ-038 Corner clip: cmd (0,0), r=2 -> 25 cycles, exactly 9 writes at (0..2,0..2), no write at x or y >= 638.
REQ-039 Edge clip: cmd (639,479), r=1 -> 4 writes at (638..639, 478..479).
REQ-040 Stall: wr_allow toggling 1,0,1,0 during r=1 paint -> 9 writes, none duplicated or skipped, completion in 17 cycles.
REQ-041 Clear priority: clear_req during PAINT plus cmd_valid held -> PAINT completes, then CLEAR with 307200 colour-0 writes, then the command is accepted.
REQ-042 Reset: reset_n low mid-CLEAR at write 1000 -> wr_en 0 at once, IDLE after release, no further writes.

Source files
------------

// File: rtl/paint_pkg.sv
// -----------------------------------------------------------------------------
// paint_pkg
// Shared types and constants for the paint scheduler and its rect scanner.
//   H_ACTIVE_DEFAULT / V_ACTIVE_DEFAULT : default visible raster size
//   color_t   : 3-bit colour code
//   coord_t   : 10-bit unsigned screen coordinate
//   scoord_t  : 11-bit signed scan coordinate (may be negative near edges)
//   ERASE_COLOR : colour written by erase strokes and by a full clear
//   state_t   : scheduler state encoding
//   in_window : true when a signed scan coordinate lies in [0, limit)
// -----------------------------------------------------------------------------
package paint_pkg;

  localparam int H_ACTIVE_DEFAULT = 640;
  localparam int V_ACTIVE_DEFAULT = 480;

  localparam int COORD_W  = 10;
  localparam int SCOORD_W = COORD_W + 1;

  typedef logic [2:0]                 color_t;
  typedef logic [COORD_W-1:0]         coord_t;
  typedef logic signed [SCOORD_W-1:0] scoord_t;

  localparam color_t ERASE_COLOR = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PAINT = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  // A negative coordinate is rejected on its sign bit, so it can never alias
  // to a large positive column or row.
  function automatic logic in_window(input scoord_t pos, input int limit);
    return !pos[SCOORD_W-1] && (int'(pos) < limit);
  endfunction

endpackage

// File: rtl/paint_scheduler_rect_scanner.sv
// -----------------------------------------------------------------------------
// rect_scanner
// Row-major walker over a rectangle of scan positions. Loaded with a signed
// top-left corner and an extent, it steps x first and wraps to the next row
// at the right edge. Shared by brush strokes and the full-screen clear.
//   clk, reset_n     : clock, asynchronous active-low reset
//   start            : load start_x/start_y and extents (wins over advance)
//   start_x, start_y : signed top-left corner of the rectangle
//   ext_x, ext_y     : rectangle width/height in positions (>= 1)
//   advance          : step to the next position
//   cur_x, cur_y     : current signed scan position
//   done             : current position is the last one of the rectangle
// -----------------------------------------------------------------------------
module rect_scanner
  import paint_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  scoord_t             start_x,
  input  scoord_t             start_y,
  input  logic [SCOORD_W-1:0] ext_x,
  input  logic [SCOORD_W-1:0] ext_y,
  input  logic                advance,
  output scoord_t             cur_x,
  output scoord_t             cur_y,
  output logic                done
);

  scoord_t first_x;
  scoord_t last_x;
  scoord_t last_y;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would make the row wrap depend on
  // statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_x   <= '0;
      cur_y   <= '0;
      first_x <= '0;
      last_x  <= '0;
      last_y  <= '0;
    end else if (start) begin
      cur_x   <= start_x;
      cur_y   <= start_y;
      first_x <= start_x;
      last_x  <= start_x + scoord_t'(ext_x) - scoord_t'(1);
      last_y  <= start_y + scoord_t'(ext_y) - scoord_t'(1);
    end else if (advance && !done) begin
      if (cur_x == last_x) begin
        cur_x <= first_x;
        cur_y <= cur_y + scoord_t'(1);
      end else begin
        cur_x <= cur_x + scoord_t'(1);
      end
    end
  end

  assign done = (cur_x == last_x) && (cur_y == last_y);

endmodule

// File: rtl/paint_scheduler.sv
// -----------------------------------------------------------------------------
// paint_scheduler
// Turns square brush commands into per-pixel writes to a pixel store and
// performs full-screen clears. A clear request is remembered while a stroke
// is in progress and runs once the scheduler is idle again, ahead of any
// waiting command.
//   Parameters : H_ACTIVE, V_ACTIVE visible columns / rows
//   clk, reset_n                 : pixel clock, asynchronous active-low reset
//   cmd_valid / cmd_ready        : command handshake
//   cmd_x, cmd_y                 : brush centre
//   cmd_color, cmd_brush         : colour, 1 = paint / 0 = erase
//   cmd_size                     : brush radius r (square side 2r+1)
//   clear_req                    : one-cycle request to clear the screen
//   wr_allow                     : pixel-store write slot this cycle
//   wr_en, wr_x, wr_y, wr_color  : pixel-store write port
//   busy                         : stroke/clear active or clear pending
// -----------------------------------------------------------------------------
module paint_scheduler
  import paint_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEFAULT,
  parameter int V_ACTIVE = V_ACTIVE_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [9:0] cmd_x,
  input  logic [9:0] cmd_y,
  input  logic [2:0] cmd_color,
  input  logic [1:0] cmd_size,
  input  logic       cmd_brush,
  input  logic       clear_req,
  input  logic       wr_allow,
  output logic       wr_en,
  output logic [9:0] wr_x,
  output logic [9:0] wr_y,
  output logic [2:0] wr_color,
  output logic       busy
);

  state_t  state;
  logic    clear_pend;
  color_t  color_q;

  // Scanner control and status
  logic                scan_start;
  scoord_t             ld_x;
  scoord_t             ld_y;
  logic [SCOORD_W-1:0] ld_w;
  logic [SCOORD_W-1:0] ld_h;
  logic                scan_advance;
  logic                scan_done;
  scoord_t             cur_x;
  scoord_t             cur_y;

  logic                active;
  logic                in_range;
  logic [SCOORD_W-1:0] radius;

  // ---------------------------------------------------------------------------
  // Scan load and step control
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the if/else leaves a value unassigned and no latch is inferred.
  always_comb begin
    radius     = {{(SCOORD_W-2){1'b0}}, cmd_size};
    scan_start = 1'b0;
    ld_x       = '0;
    ld_y       = '0;
    ld_w       = '0;
    ld_h       = '0;
    if (state == ST_IDLE) begin
      if (clear_pend) begin
        scan_start = 1'b1;
        ld_w       = SCOORD_W'(H_ACTIVE);
        ld_h       = SCOORD_W'(V_ACTIVE);
      end else if (cmd_valid) begin
        // Signed arithmetic keeps a centre near 0 from wrapping to ~1023.
        scan_start = 1'b1;
        ld_x       = $signed({1'b0, cmd_x}) - $signed(radius);
        ld_y       = $signed({1'b0, cmd_y}) - $signed(radius);
        ld_w       = {{(SCOORD_W-3){1'b0}}, cmd_size, 1'b1};
        ld_h       = {{(SCOORD_W-3){1'b0}}, cmd_size, 1'b1};
      end
    end
  end

  assign active   = (state != ST_IDLE);
  assign in_range = in_window(cur_x, H_ACTIVE) && in_window(cur_y, V_ACTIVE);

  // Off-screen positions are skipped one per cycle; on-screen positions wait
  // for a write slot, so nothing is dropped while wr_allow is low.
  assign scan_advance = active && (in_range ? wr_allow : 1'b1);

  rect_scanner u_scanner (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (scan_start),
    .start_x (ld_x),
    .start_y (ld_y),
    .ext_x   (ld_w),
    .ext_y   (ld_h),
    .advance (scan_advance),
    .cur_x   (cur_x),
    .cur_y   (cur_y),
    .done    (scan_done)
  );

  // ---------------------------------------------------------------------------
  // Scheduler state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      clear_pend <= 1'b0;
      color_q    <= ERASE_COLOR;
    end else begin
      if (clear_req && (state != ST_CLEAR)) begin
        clear_pend <= 1'b1;
      end
      unique case (state)
        ST_IDLE: begin
          if (clear_pend) begin
            // Starting the clear consumes the request; a request arriving in
            // this same cycle is covered by the clear that is starting.
            state      <= ST_CLEAR;
            clear_pend <= 1'b0;
            color_q    <= ERASE_COLOR;
          end else if (cmd_valid) begin
            state   <= ST_PAINT;
            color_q <= cmd_brush ? color_t'(cmd_color) : ERASE_COLOR;
          end
        end
        ST_PAINT, ST_CLEAR: begin
          if (scan_advance && scan_done) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // reset_n is folded in so the handshake is closed for the whole reset
  // window and opens as soon as reset is released.
  assign cmd_ready = reset_n && (state == ST_IDLE) && !clear_pend;
  assign busy      = active || clear_pend;
  assign wr_en     = active && in_range && wr_allow;
  assign wr_x      = coord_t'(cur_x[COORD_W-1:0]);
  assign wr_y      = coord_t'(cur_y[COORD_W-1:0]);
  assign wr_color  = color_q;

endmodule

// File: tb/tb_paint_scheduler.sv
module tb_paint_scheduler;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] c;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  // Full-size instance: brush strokes and clipping
  logic       cmd_valid, cmd_ready, cmd_brush, clear_req, wr_allow, wr_en, busy;
  logic [9:0] cmd_x, cmd_y, wr_x, wr_y;
  logic [2:0] cmd_color, wr_color;
  logic [1:0] cmd_size;

  // Small instance: clears short enough to run completely
  logic       s_cmd_valid, s_cmd_ready, s_cmd_brush, s_clear_req, s_wr_allow, s_wr_en, s_busy;
  logic [9:0] s_cmd_x, s_cmd_y, s_wr_x, s_wr_y;
  logic [2:0] s_cmd_color, s_wr_color;
  logic [1:0] s_cmd_size;

  localparam int SH = 64;
  localparam int SV = 32;

  paint_scheduler dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_color(cmd_color), .cmd_size(cmd_size),
    .cmd_brush(cmd_brush), .clear_req(clear_req), .wr_allow(wr_allow),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color), .busy(busy)
  );

  paint_scheduler #(.H_ACTIVE(SH), .V_ACTIVE(SV)) dut_s (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready),
    .cmd_x(s_cmd_x), .cmd_y(s_cmd_y), .cmd_color(s_cmd_color), .cmd_size(s_cmd_size),
    .cmd_brush(s_cmd_brush), .clear_req(s_clear_req), .wr_allow(s_wr_allow),
    .wr_en(s_wr_en), .wr_x(s_wr_x), .wr_y(s_wr_y), .wr_color(s_wr_color), .busy(s_busy)
  );

  int checks = 0;
  int errors = 0;

  wr_t big_log[$];
  wr_t small_log[$];
  wr_t exp_q[$];

  // Writes are taken on the rising edge; record them mid-cycle.
  always @(negedge clk) begin
    if (wr_en)   big_log.push_back({wr_x, wr_y, wr_color});
    if (s_wr_en) small_log.push_back({s_wr_x, s_wr_y, s_wr_color});
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference: clipped square, row-major
  function automatic void model_paint(input int cx, input int cy, input int r,
                                      input logic [2:0] c, input int h, input int v);
    for (int y = cy - r; y <= cy + r; y++)
      for (int x = cx - r; x <= cx + r; x++)
        if (x >= 0 && x < h && y >= 0 && y < v)
          exp_q.push_back({10'(x), 10'(y), c});
  endfunction

  function automatic void model_clear(input int h, input int v);
    for (int y = 0; y < v; y++)
      for (int x = 0; x < h; x++)
        exp_q.push_back({10'(x), 10'(y), 3'b000});
  endfunction

  // Issue one command on the full-size instance and run it to completion.
  task automatic run_paint(input int x, input int y, input int r, input logic [2:0] c,
                           input logic brush, input logic toggle, output int cycles);
    big_log.delete();
    cmd_x = 10'(x); cmd_y = 10'(y); cmd_size = 2'(r); cmd_color = c; cmd_brush = brush;
    cmd_valid = 1'b1;
    wr_allow  = 1'b1;
    cyc();
    cmd_valid = 1'b0;
    cycles = 0;
    while (!cmd_ready && cycles < 200) begin
      wr_allow = toggle ? ((cycles % 2) == 0) : 1'b1;
      cyc();
      cycles++;
    end
    wr_allow = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cmd_valid = 0; cmd_x = 0; cmd_y = 0; cmd_color = 0; cmd_size = 0; cmd_brush = 0;
    clear_req = 0; wr_allow = 0;
    s_cmd_valid = 0; s_cmd_x = 0; s_cmd_y = 0; s_cmd_color = 0; s_cmd_size = 0; s_cmd_brush = 0;
    s_clear_req = 0; s_wr_allow = 0;
    #12;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready got %b exp 0", cmd_ready); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (wr_en !== 1'b0)     begin errors++; $display("FAIL reset_wr_en got %b exp 0", wr_en); end
    checks++; if ({wr_x, wr_y, wr_color} !== 23'd0)
      begin errors++; $display("FAIL reset_wr_bus got %0d,%0d,%0d exp 0,0,0", wr_x, wr_y, wr_color); end
    checks++; if (s_cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_s_cmd_ready got %b exp 0", s_cmd_ready); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL post_reset_cmd_ready got %b exp 1", cmd_ready); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL post_reset_busy got %b exp 0", busy); end
    cyc();
  endtask

  task automatic test_basic_paint();
    int cycles;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_before got %b exp 1", cmd_ready); end
    run_paint(100, 50, 1, 3'd5, 1'b1, 1'b0, cycles);
    exp_q.delete();
    model_paint(100, 50, 1, 3'd5, 640, 480);
    checks++; if (cycles != 9) begin errors++; $display("FAIL basic_cycles got %0d exp 9", cycles); end
    checks++; if (big_log.size() != 9) begin errors++; $display("FAIL basic_count got %0d exp 9", big_log.size()); end
    if (big_log.size() == 9) begin
      checks++; if (big_log[0] !== {10'd99, 10'd49, 3'd5})
        begin errors++; $display("FAIL basic_first got (%0d,%0d,%0d) exp (99,49,5)", big_log[0].x, big_log[0].y, big_log[0].c); end
      checks++; if (big_log[8] !== {10'd101, 10'd51, 3'd5})
        begin errors++; $display("FAIL basic_last got (%0d,%0d,%0d) exp (101,51,5)", big_log[8].x, big_log[8].y, big_log[8].c); end
    end
    for (int i = 0; i < exp_q.size() && i < big_log.size(); i++) begin
      checks++;
      if (big_log[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL basic_write[%0d] got (%0d,%0d,%0d) exp (%0d,%0d,%0d)", i,
                 big_log[i].x, big_log[i].y, big_log[i].c, exp_q[i].x, exp_q[i].y, exp_q[i].c);
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b exp 0", busy); end
  endtask

  task automatic test_corner_clip();
    int cycles;
    int aliased;
    run_paint(0, 0, 2, 3'd2, 1'b1, 1'b0, cycles);
    exp_q.delete();
    model_paint(0, 0, 2, 3'd2, 640, 480);
    checks++; if (cycles != 25) begin errors++; $display("FAIL corner_cycles got %0d exp 25", cycles); end
    checks++; if (big_log.size() != 9) begin errors++; $display("FAIL corner_count got %0d exp 9", big_log.size()); end
    aliased = 0;
    foreach (big_log[i]) if (big_log[i].x >= 10'd638 || big_log[i].y >= 10'd478) aliased++;
    checks++; if (aliased != 0) begin errors++; $display("FAIL corner_alias got %0d exp 0", aliased); end
    for (int i = 0; i < exp_q.size() && i < big_log.size(); i++) begin
      checks++;
      if (big_log[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL corner_write[%0d] got (%0d,%0d,%0d) exp (%0d,%0d,%0d)", i,
                 big_log[i].x, big_log[i].y, big_log[i].c, exp_q[i].x, exp_q[i].y, exp_q[i].c);
      end
    end
  endtask

  task automatic test_edge_clip();
    int cycles;
    run_paint(639, 479, 1, 3'd7, 1'b1, 1'b0, cycles);
    exp_q.delete();
    exp_q.push_back({10'd638, 10'd478, 3'd7});
    exp_q.push_back({10'd639, 10'd478, 3'd7});
    exp_q.push_back({10'd638, 10'd479, 3'd7});
    exp_q.push_back({10'd639, 10'd479, 3'd7});
    checks++; if (cycles != 9) begin errors++; $display("FAIL edge_cycles got %0d exp 9", cycles); end
    checks++; if (big_log.size() != 4) begin errors++; $display("FAIL edge_count got %0d exp 4", big_log.size()); end
    for (int i = 0; i < exp_q.size() && i < big_log.size(); i++) begin
      checks++;
      if (big_log[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL edge_write[%0d] got (%0d,%0d,%0d) exp (%0d,%0d,%0d)", i,
                 big_log[i].x, big_log[i].y, big_log[i].c, exp_q[i].x, exp_q[i].y, exp_q[i].c);
      end
    end
  endtask

  task automatic test_stall();
    int cycles;
    run_paint(300, 200, 1, 3'd4, 1'b1, 1'b1, cycles);
    exp_q.delete();
    model_paint(300, 200, 1, 3'd4, 640, 480);
    checks++; if (cycles != 17) begin errors++; $display("FAIL stall_cycles got %0d exp 17", cycles); end
    checks++; if (big_log.size() != 9) begin errors++; $display("FAIL stall_count got %0d exp 9", big_log.size()); end
    for (int i = 0; i < exp_q.size() && i < big_log.size(); i++) begin
      checks++;
      if (big_log[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL stall_write[%0d] got (%0d,%0d,%0d) exp (%0d,%0d,%0d)", i,
                 big_log[i].x, big_log[i].y, big_log[i].c, exp_q[i].x, exp_q[i].y, exp_q[i].c);
      end
    end
  endtask

  task automatic test_erase();
    int cycles;
    run_paint(10, 10, 0, 3'd7, 1'b0, 1'b0, cycles);
    checks++; if (cycles != 1) begin errors++; $display("FAIL erase_cycles got %0d exp 1", cycles); end
    checks++; if (big_log.size() != 1) begin errors++; $display("FAIL erase_count got %0d exp 1", big_log.size()); end
    if (big_log.size() >= 1) begin
      checks++; if (big_log[0] !== {10'd10, 10'd10, 3'd0})
        begin errors++; $display("FAIL erase_write got (%0d,%0d,%0d) exp (10,10,0)", big_log[0].x, big_log[0].y, big_log[0].c); end
    end
  endtask

  task automatic test_clear_priority();
    int  n;
    bit  second_sent;
    bit  acc;
    int  mism;
    small_log.delete();
    exp_q.delete();
    s_wr_allow = 1'b1;
    s_cmd_x = 10'd5; s_cmd_y = 10'd5; s_cmd_size = 2'd1; s_cmd_color = 3'd3; s_cmd_brush = 1'b1;
    s_cmd_valid = 1'b1;
    cyc();
    // Next command held valid through the stroke and the clear.
    s_cmd_x = 10'd20; s_cmd_y = 10'd20; s_cmd_size = 2'd0; s_cmd_color = 3'd6;
    s_clear_req = 1'b1;
    cyc();
    s_clear_req = 1'b0;
    checks++; if (s_busy !== 1'b1)      begin errors++; $display("FAIL clrpri_busy got %b exp 1", s_busy); end
    checks++; if (s_cmd_ready !== 1'b0) begin errors++; $display("FAIL clrpri_ready_in_paint got %b exp 0", s_cmd_ready); end
    n = 0;
    second_sent = 1'b0;
    while ((s_cmd_valid || s_busy) && n < 6000) begin
      // A request during the clear itself must be ignored.
      if (!second_sent && small_log.size() == 109) begin
        s_clear_req = 1'b1;
        second_sent = 1'b1;
      end else begin
        s_clear_req = 1'b0;
      end
      acc = s_cmd_valid && s_cmd_ready;
      cyc();
      n++;
      if (acc) s_cmd_valid = 1'b0;
    end
    s_clear_req = 1'b0;
    repeat (5) cyc();
    model_paint(5, 5, 1, 3'd3, SH, SV);
    model_clear(SH, SV);
    model_paint(20, 20, 0, 3'd6, SH, SV);
    checks++; if (n >= 6000) begin errors++; $display("FAIL clrpri_timeout got %0d cycles exp < 6000", n); end
    checks++; if (small_log.size() != exp_q.size())
      begin errors++; $display("FAIL clrpri_count got %0d exp %0d", small_log.size(), exp_q.size()); end
    mism = 0;
    for (int i = 0; i < exp_q.size() && i < small_log.size(); i++) begin
      checks++;
      if (small_log[i] !== exp_q[i]) begin
        errors++;
        if (mism < 5)
          $display("FAIL clrpri_write[%0d] got (%0d,%0d,%0d) exp (%0d,%0d,%0d)", i,
                   small_log[i].x, small_log[i].y, small_log[i].c, exp_q[i].x, exp_q[i].y, exp_q[i].c);
        mism++;
      end
    end
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL clrpri_busy_end got %b exp 0", s_busy); end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    small_log.delete();
    s_wr_allow  = 1'b1;
    s_clear_req = 1'b1;
    cyc();
    s_clear_req = 1'b0;
    n = 0;
    while (small_log.size() < 1000 && n < 3000) begin
      cyc();
      n++;
    end
    checks++; if (small_log.size() != 1000) begin errors++; $display("FAIL rstclr_reach got %0d exp 1000", small_log.size()); end
    if (small_log.size() == 1000) begin
      checks++; if (small_log[999] !== {10'd39, 10'd15, 3'd0})
        begin errors++; $display("FAIL rstclr_w999 got (%0d,%0d,%0d) exp (39,15,0)", small_log[999].x, small_log[999].y, small_log[999].c); end
    end
    checks++; if (s_wr_en !== 1'b1) begin errors++; $display("FAIL rstclr_active got %b exp 1", s_wr_en); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (s_wr_en !== 1'b0)     begin errors++; $display("FAIL rstclr_wr_en got %b exp 0", s_wr_en); end
    checks++; if (s_busy !== 1'b0)      begin errors++; $display("FAIL rstclr_busy got %b exp 0", s_busy); end
    checks++; if (s_cmd_ready !== 1'b0) begin errors++; $display("FAIL rstclr_ready got %b exp 0", s_cmd_ready); end
    checks++; if ({s_wr_x, s_wr_y, s_wr_color} !== 23'd0)
      begin errors++; $display("FAIL rstclr_wr_bus got %0d,%0d,%0d exp 0,0,0", s_wr_x, s_wr_y, s_wr_color); end
    cyc();
    cyc();
    reset_n = 1'b1;
    repeat (20) cyc();
    checks++; if (small_log.size() != 1000) begin errors++; $display("FAIL rstclr_no_resume got %0d exp 1000", small_log.size()); end
    checks++; if (s_busy !== 1'b0)      begin errors++; $display("FAIL rstclr_idle_busy got %b exp 0", s_busy); end
    checks++; if (s_cmd_ready !== 1'b1) begin errors++; $display("FAIL rstclr_idle_ready got %b exp 1", s_cmd_ready); end
  endtask

  initial begin
    test_reset();
    test_basic_paint();
    test_corner_clip();
    test_edge_clip();
    test_stall();
    test_erase();
    test_clear_priority();
    test_reset_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
